// File: rtl/ivl_uvm_ovl_one_cold_mc_if.sv
// Check bus for the multi-channel one-cold/one-hot checker: stimulus in, per-channel verdicts out.
interface ivl_uvm_ovl_one_cold_mc_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS*WIDTH-1:0] test_expr;
    logic                      clr_counts;
    logic [CHANNELS-1:0]       fire;
    logic [CHANNELS-1:0]       fire_x;
    logic [CHANNELS*CNT_W-1:0] fail_count;
    logic [CHANNELS-1:0]       halted;
    logic                      any_fire;

    modport master (
        output enable, test_expr, clr_counts,
        input  fire, fire_x, fail_count, halted, any_fire
    );
    modport slave (
        input  enable, test_expr, clr_counts,
        output fire, fire_x, fail_count, halted, any_fire
    );
endinterface

// File: rtl/ivl_uvm_ovl_one_cold_mc.sv
// Multi-channel one-cold/one-hot checker: per-channel arming, X/Z flagging,
// saturating failure counters and halt-after-N. Observes only.
module ivl_uvm_ovl_one_cold_mc_chan #(
    parameter int WIDTH      = 4,
    parameter int MODE       = 0,
    parameter int INACTIVE   = 0,
    parameter int X_CHECK    = 1,
    parameter int ARM_CYCLES = 2,
    parameter int CNT_W      = 8,
    parameter int MAX_FAILS  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] slice,
    input  logic             clr,
    output logic             fire,
    output logic             fire_x,
    output logic [CNT_W-1:0] count,
    output logic             halted
);
    localparam int AW = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);
    localparam logic [AW:0]      ARM_L = ARM_CYCLES[AW:0];
    localparam logic [CNT_W-1:0] MAX_L = MAX_FAILS[CNT_W-1:0];

    typedef enum logic [1:0] {WARMUP, CHECK, HALT} st_t;

    st_t              st, st_nxt;
    logic [AW-1:0]    arm, arm_nxt;
    logic [AW:0]      arm_p1;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_base;
    logic             fire_q, fx_q;
    logic             chk, is_x, legal, viol, fx_d;
    int unsigned      ones;

    always_ff @(posedge clock) begin
        if (reset) begin
            st     <= WARMUP;
            arm    <= '0;
            cnt    <= '0;
            fire_q <= 1'b0;
            fx_q   <= 1'b0;
        end else begin
            st     <= st_nxt;
            arm    <= arm_nxt;
            cnt    <= cnt_nxt;
            fire_q <= viol;
            fx_q   <= fx_d;
        end
    end

    always_comb begin
        st_nxt  = st;
        arm_nxt = arm;
        arm_p1  = {1'b0, arm} + 1'b1;
        case (st)
            WARMUP: begin
                if (!enable) arm_nxt = '0;
                else begin
                    arm_nxt = arm_p1[AW-1:0];
                    if (arm_p1 >= ARM_L) st_nxt = CHECK;
                end
            end
            CHECK: if (!enable) begin
                st_nxt  = WARMUP;
                arm_nxt = '0;
            end
            default: if (clr) begin
                st_nxt  = WARMUP;
                arm_nxt = '0;
            end
        endcase
        if (viol && MAX_FAILS != 0 && cnt_nxt == MAX_L) st_nxt = HALT;
    end

    // Evaluation and count update; X/Z bits force a violation when not flagged separately.
    always_comb begin
        ones = 0;
        for (int i = 0; i < WIDTH; i++) ones = ones + int'(slice[i]);
        is_x = $isunknown(slice);
        case (MODE)
            0:       legal = (ones == WIDTH - 1);
            1:       legal = (ones == 1);
            default: legal = (ones <= 1);
        endcase
        if (INACTIVE == 1 && slice == '0) legal = 1'b1;
        if (INACTIVE == 2 && slice == '1) legal = 1'b1;
        chk      = enable && (st == CHECK || (st == WARMUP && ARM_CYCLES == 0));
        fx_d     = chk && (X_CHECK != 0) && is_x;
        viol     = chk && !fx_d && (is_x || !legal);
        cnt_base = clr ? '0 : cnt;
        cnt_nxt  = (viol && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
        fire     = fire_q;
        fire_x   = fx_q;
        count    = cnt;
        halted   = (st == HALT);
    end
endmodule

module ivl_uvm_ovl_one_cold_mc #(
    parameter int WIDTH      = 4,
    parameter int CHANNELS   = 1,
    parameter int MODE       = 0,
    parameter int INACTIVE   = 0,
    parameter int X_CHECK    = 1,
    parameter int ARM_CYCLES = 2,
    parameter int CNT_W      = 8,
    parameter int MAX_FAILS  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    ivl_uvm_ovl_one_cold_mc_if.slave    bus
);
    logic [CHANNELS-1:0]            fire_v, fx_v, halt_v;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_v;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ivl_uvm_ovl_one_cold_mc_chan #(
            .WIDTH(WIDTH), .MODE(MODE), .INACTIVE(INACTIVE), .X_CHECK(X_CHECK),
            .ARM_CYCLES(ARM_CYCLES), .CNT_W(CNT_W), .MAX_FAILS(MAX_FAILS)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .enable (bus.enable[c]),
            .slice  (bus.test_expr[c*WIDTH +: WIDTH]),
            .clr    (bus.clr_counts),
            .fire   (fire_v[c]),
            .fire_x (fx_v[c]),
            .count  (cnt_v[c]),
            .halted (halt_v[c])
        );
    end

    assign bus.fire       = fire_v;
    assign bus.fire_x     = fx_v;
    assign bus.halted     = halt_v;
    assign bus.fail_count = cnt_v;
    assign bus.any_fire   = |fire_v;
endmodule
